rn_local_eject_buffer: RTL



---
 rtl/rn_local_eject_buffer.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/rn_local_eject_buffer.sv
// rn_local_eject_buffer: ejection buffer between a mesh router's local output
// port and a requester/cache node. Incoming flits are stored per virtual
// channel, delivered to the device through a valid/ready interface with
// round-robin arbitration over non-empty VCs, and every drained flit returns
// one credit to the router. The sender's linear node id is recovered from the
// head flit's src_id.
// Optional build macro: RN_EJECT_TGT_CHECK_EN -- when defined, flits whose
// tgt_id does not match this node are dropped, flagged on misroute_err_o and
// their credit is returned immediately.
// Flit layout: tgt_id {y,x} starts at bit TGT_ID_LSB, src_id {y,x} starts at
// bit SRC_ID_LSB (x in the low bits of each id).
module rn_local_eject_buffer #(
  parameter type flit_payload_t      = logic [256-1:0],
  parameter int  VC_NUM              = 2,
  parameter int  VC_DEPTH            = 4,
  parameter int  VC_ID_W             = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  parameter int  NodeID_X_Width      = 2,
  parameter int  NodeID_Y_Width      = 2,
  parameter int  NODE_NUM_X_DIMESION = 4,
  parameter int  TGT_ID_LSB          = 0,
  parameter int  SRC_ID_LSB          = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NodeID_X_Width-1:0]              node_id_x_i,
  input  logic [NodeID_Y_Width-1:0]              node_id_y_i,
  input  logic                                   flit_v_i,
  input  flit_payload_t                          flit_i,
  input  logic [VC_ID_W-1:0]                     flit_vc_id_i,
  output logic                                   lcrd_v_o,
  output logic [VC_ID_W-1:0]                     lcrd_vc_id_o,
  output logic                                   rx_valid_o,
  input  logic                                   rx_ready_i,
  output flit_payload_t                          rx_flit_o,
  output logic [NodeID_X_Width+NodeID_Y_Width-1:0] rx_src_nid_o,
  output logic                                   overflow_err_o,
  output logic                                   misroute_err_o
);

  localparam int AW = $clog2(VC_DEPTH);
  localparam int PW = AW + 1;
  localparam int NW = NodeID_X_Width + NodeID_Y_Width;

  logic [VC_NUM-1:0]  empty;
  logic [VC_NUM-1:0]  full;
  logic [VC_NUM-1:0]  push_vc;
  logic [VC_NUM-1:0]  ovf_vc;
  flit_payload_t      head [VC_NUM];

  logic               flit_ok;
  logic               pop;
  logic               rr_found;
  int                 rr_idx;
  logic [VC_ID_W-1:0] rr_grant;
  logic [VC_ID_W-1:0] grant_vc;
  logic [VC_ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic               lock_q, lock_d;
  logic [VC_ID_W-1:0] lock_vc_q;
  logic               lcrd_v_q, lcrd_v_d;
  logic [VC_ID_W-1:0] lcrd_vc_q, lcrd_vc_d;
  logic               ovf_q, ovf_d;

  // Per-VC circular FIFO. Full/empty use the extra pointer MSB, and the full
  // check sees pre-pop occupancy, so a push into a full VC is an overflow even
  // when that VC pops in the same cycle.
  for (genvar gi = 0; gi < VC_NUM; gi++) begin : g_vc
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    flit_payload_t mem_q [VC_DEPTH];
    logic          pop_here;

    assign empty[gi]   = (wr_ptr_q == rd_ptr_q);
    assign full[gi]    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_vc[gi] = flit_ok && (flit_vc_id_i == VC_ID_W'(gi)) && !full[gi];
    assign ovf_vc[gi]  = flit_ok && (flit_vc_id_i == VC_ID_W'(gi)) && full[gi];
    assign pop_here    = pop && (grant_vc == VC_ID_W'(gi));
    assign head[gi]    = mem_q[rd_ptr_q[AW-1:0]];

    // Advance write pointer on accepted push, read pointer on delivery.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_vc[gi]) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop_here)    rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end

    // Flit storage; contents need no reset since the pointers gate validity.
    always_ff @(posedge clk) begin
      if (push_vc[gi]) mem_q[wr_ptr_q[AW-1:0]] <= flit_i;
    end
  end

  // Round-robin pick: first non-empty VC at or after rr_ptr.
  always_comb begin
    rr_grant = '0;
    rr_found = 1'b0;
    rr_idx   = 0;
    for (int i = 0; i < VC_NUM; i++) begin
      rr_idx = int'(rr_ptr_q) + i;
      if (rr_idx >= VC_NUM) rr_idx = rr_idx - VC_NUM;
      if (!rr_found && !empty[rr_idx]) begin
        rr_found = 1'b1;
        rr_grant = VC_ID_W'(rr_idx);
      end
    end
  end

  // A stalled offer keeps its VC so the presented flit cannot change.
  assign grant_vc   = lock_q ? lock_vc_q : rr_grant;
  assign rx_valid_o = ~&empty;
  assign rx_flit_o  = head[grant_vc];
  assign pop        = rx_valid_o && rx_ready_i;
  assign rx_src_nid_o =
      NW'(rx_flit_o[SRC_ID_LSB+NodeID_X_Width +: NodeID_Y_Width]) * NW'(NODE_NUM_X_DIMESION) +
      NW'(rx_flit_o[SRC_ID_LSB +: NodeID_X_Width]);

  // Next arbitration state: rotate past the VC just served, lock on stall.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    lock_d   = rx_valid_o && !rx_ready_i;
    ovf_d    = ovf_q | (|ovf_vc);
    if (pop) begin
      if (int'(grant_vc) == VC_NUM - 1) rr_ptr_d = '0;
      else                              rr_ptr_d = grant_vc + VC_ID_W'(1);
    end
  end

  // Arbitration, credit and sticky overflow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_vc_q <= '0;
      lcrd_v_q  <= 1'b0;
      lcrd_vc_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      lock_vc_q <= grant_vc;
      lcrd_v_q  <= lcrd_v_d;
      lcrd_vc_q <= lcrd_vc_d;
      ovf_q     <= ovf_d;
    end
  end

  assign lcrd_v_o       = lcrd_v_q;
  assign lcrd_vc_id_o   = lcrd_vc_q;
  assign overflow_err_o = ovf_q;

`ifdef RN_EJECT_TGT_CHECK_EN
  logic               misroute;
  logic               mis_err_q;
  logic               mis_pend_q, mis_pend_d;
  logic [VC_ID_W-1:0] mis_pend_vc_q, mis_pend_vc_d;

  assign misroute = flit_v_i &&
      ((flit_i[TGT_ID_LSB +: NodeID_X_Width] != node_id_x_i) ||
       (flit_i[TGT_ID_LSB+NodeID_X_Width +: NodeID_Y_Width] != node_id_y_i));
  assign flit_ok  = flit_v_i && !misroute;

  // Credit select: pop credit first, then a deferred misroute credit, then a
  // fresh one. The single holding slot only covers isolated collisions; the
  // router's credit budget keeps back-to-back collisions from occurring.
  always_comb begin
    lcrd_v_d      = 1'b0;
    lcrd_vc_d     = '0;
    mis_pend_d    = mis_pend_q;
    mis_pend_vc_d = mis_pend_vc_q;
    if (pop) begin
      lcrd_v_d  = 1'b1;
      lcrd_vc_d = grant_vc;
      if (misroute) begin
        mis_pend_d    = 1'b1;
        mis_pend_vc_d = flit_vc_id_i;
      end
    end else if (mis_pend_q) begin
      lcrd_v_d      = 1'b1;
      lcrd_vc_d     = mis_pend_vc_q;
      mis_pend_d    = misroute;
      mis_pend_vc_d = flit_vc_id_i;
    end else if (misroute) begin
      lcrd_v_d  = 1'b1;
      lcrd_vc_d = flit_vc_id_i;
    end
  end

  // Sticky misroute flag and the deferred credit slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_err_q     <= 1'b0;
      mis_pend_q    <= 1'b0;
      mis_pend_vc_q <= '0;
    end else begin
      mis_err_q     <= mis_err_q | misroute;
      mis_pend_q    <= mis_pend_d;
      mis_pend_vc_q <= mis_pend_vc_d;
    end
  end

  assign misroute_err_o = mis_err_q;
`else
  logic unused_node_id;
  assign unused_node_id = ^{node_id_x_i, node_id_y_i};
  assign flit_ok        = flit_v_i;

  // Without the target check every credit comes from a pop.
  always_comb begin
    lcrd_v_d  = pop;
    lcrd_vc_d = grant_vc;
  end

  assign misroute_err_o = 1'b0;
`endif

endmodule
